// File: rtl/furv_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states
// and the alignment rule used to reject bad requests before the bus.
package furv_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic bad;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// CPU request/response port plus Wishbone classic initiator signals.
// master = the load/store unit, slave = CPU and bus responder side.
interface wb_lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [3:0]        wb_sel;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack;

    modport master (
        input  req_valid, req_we, req_addr, req_size,
        input  req_unsigned, req_wdata, wb_dat_i, wb_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dat_o
    );

    modport slave (
        output req_valid, req_we, req_addr, req_size,
        output req_unsigned, req_wdata, wb_dat_i, wb_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dat_o
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: lane enables, store replication, load lane
// extraction with sign/zero extension, and the alignment check.
module lsu_align
    import furv_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  sel,
    output logic [31:0] dat_o,
    output logic [31:0] rdata,
    output logic        err
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_raw >> {addr_lo, 3'b000};
        sel     = 4'b0000;
        dat_o   = wdata;
        rdata   = 32'h0;
        unique case (size)
            SZ_B: begin
                sel   = 4'b0001 << addr_lo;
                dat_o = {4{wdata[7:0]}};
                rdata = uns ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                sel   = 4'b0011 << addr_lo;
                dat_o = {2{wdata[15:0]}};
                rdata = uns ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                sel   = 4'b1111;
                rdata = shifted;
            end
            default: begin
                sel   = 4'b0000;
                rdata = 32'h0;
            end
        endcase
        err = misaligned(size, addr_lo);
    end

endmodule

// File: rtl/wb_lsu.sv
// Single-outstanding load/store unit bridging CPU requests onto a
// Wishbone classic bus, with alignment checking and ack timeout.
module wb_lsu
    import furv_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst,
    wb_lsu_if.master bus
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        alo_q, alo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic              wbwe_q, wbwe_d;
    logic [ADDR_W-1:0] wadr_q, wadr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dato_q, dato_d;
    logic              rvld_q, rvld_d;
    logic              rerr_q, rerr_d;
    logic [31:0]       rdat_q, rdat_d;

    logic              idle;
    logic [1:0]        a_size;
    logic [1:0]        a_alo;
    logic              a_uns;
    logic [3:0]        a_sel;
    logic [31:0]       a_dato;
    logic [31:0]       a_rdata;
    logic              a_err;
    logic              unused_ok;

    assign idle = (state_q == S_IDLE);

    // One steering instance: fed from the live request while idle
    // and from the latched request once the access is in flight.
    assign a_size = idle ? bus.req_size          : size_q;
    assign a_alo  = idle ? bus.req_addr[1:0]     : alo_q;
    assign a_uns  = idle ? bus.req_unsigned      : uns_q;

    lsu_align u_align (
        .size      (a_size),
        .addr_lo   (a_alo),
        .uns       (a_uns),
        .wdata     (bus.req_wdata),
        .rdata_raw (bus.wb_dat_i),
        .sel       (a_sel),
        .dat_o     (a_dato),
        .rdata     (a_rdata),
        .err       (a_err)
    );

    assign unused_ok = ^{bus.req_addr[31:ADDR_W+2]};

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        alo_d   = alo_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        wbwe_d  = wbwe_q;
        wadr_d  = wadr_q;
        sel_d   = sel_q;
        dato_d  = dato_q;
        rvld_d  = 1'b0;
        rerr_d  = 1'b0;
        rdat_d  = rdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    alo_d  = bus.req_addr[1:0];
                    wadr_d = bus.req_addr[ADDR_W+1:2];
                    sel_d  = a_sel;
                    dato_d = a_dato;
                    if (a_err) begin
                        state_d = S_RESP;
                        rvld_d  = 1'b1;
                        rerr_d  = 1'b1;
                        rdat_d  = 32'h0;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        wbwe_d  = bus.req_we;
                        cnt_d   = '0;
                    end
                end
            end
            S_BUS: begin
                if (bus.wb_ack) begin
                    state_d = S_RESP;
                    cyc_d   = 1'b0;
                    wbwe_d  = 1'b0;
                    rvld_d  = 1'b1;
                    rdat_d  = we_q ? 32'h0 : a_rdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_CNT) begin
                        state_d = S_RESP;
                        cyc_d   = 1'b0;
                        wbwe_d  = 1'b0;
                        rvld_d  = 1'b1;
                        rerr_d  = 1'b1;
                        rdat_d  = 32'h0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            alo_q   <= 2'b00;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            wbwe_q  <= 1'b0;
            wadr_q  <= '0;
            sel_q   <= 4'b0000;
            dato_q  <= 32'h0;
            rvld_q  <= 1'b0;
            rerr_q  <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            alo_q   <= alo_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            wbwe_q  <= wbwe_d;
            wadr_q  <= wadr_d;
            sel_q   <= sel_d;
            dato_q  <= dato_d;
            rvld_q  <= rvld_d;
            rerr_q  <= rerr_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.req_ready  = idle;
    assign bus.wb_cyc     = cyc_q;
    assign bus.wb_stb     = cyc_q;
    assign bus.wb_we      = wbwe_q;
    assign bus.wb_addr    = wadr_q;
    assign bus.wb_sel     = sel_q;
    assign bus.wb_dat_o   = dato_q;
    assign bus.resp_valid = rvld_q;
    assign bus.resp_err   = rerr_q;
    assign bus.resp_rdata = rdat_q;

endmodule
